// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, clog2 helper and the count-width rule.
package fifo_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_DEPTH  = 4;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy counter width: one extra bit so that DEPTH itself is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer bus of param_fifo; slave is the FIFO, master is the attached stage.
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) ();

    localparam int unsigned CW = cnt_w(DEPTH);

    logic              clr;
    logic              enq;
    logic [DATA_W-1:0] din;
    logic              deq;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, enq, din, deq,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, enq, din, deq,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Storage array; intentionally not reset, entries are always written before being read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; holds its value when no read is issued.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with occupancy count, threshold flags, sticky error flags and flush.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic         clk,
    input  logic         nrst,
    param_fifo_if.slave  bus
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     count;
    logic              dout_valid;
    logic              overflow;
    logic              underflow;
    logic [DATA_W-1:0] rdata;

    logic full_c;
    logic empty_c;
    logic wr_ok_c;
    logic rd_ok_c;
    logic we_c;
    logic re_c;

    // Status decodes straight off the registered count.
    always_comb begin
        full_c  = (count == FULL_LVL);
        empty_c = (count == '0);
    end

    // Accept decisions; a flush suppresses both memory ports, reset suppresses writes.
    always_comb begin
        wr_ok_c = bus.enq & (~full_c | bus.deq);
        rd_ok_c = bus.deq & ~empty_c;
        we_c    = wr_ok_c & ~bus.clr & nrst;
        re_c    = rd_ok_c & ~bus.clr;
    end

    // Pointers, occupancy, read-valid pulse and sticky error flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (bus.clr) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                tail <= tail + AW'(1);
            end
            if (rd_ok_c) begin
                head <= head + AW'(1);
            end
            count      <= count + CW'(wr_ok_c) - CW'(rd_ok_c);
            dout_valid <= rd_ok_c;
            if (bus.enq && !wr_ok_c) begin
                overflow <= 1'b1;
            end
            if (bus.deq && !rd_ok_c) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .nrst  (nrst),
        .we    (we_c),
        .waddr (tail),
        .wdata (bus.din),
        .re    (re_c),
        .raddr (head),
        .rdata (rdata)
    );

    // Drive the bus outputs.
    always_comb begin
        bus.dout         = rdata;
        bus.dout_valid   = dout_valid;
        bus.count        = count;
        bus.full         = full_c;
        bus.empty        = empty_c;
        bus.almost_full  = (count >= AF_LVL);
        bus.almost_empty = (count <= AE_LVL);
        bus.overflow     = overflow;
        bus.underflow    = underflow;
    end

endmodule
